// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, absorbs the one-cycle imem
// read latency, and handles stall skid, redirect/flush, halt and illegal targets.
module imem_fetch_ctrl #(
    parameter int unsigned        ADDR_W     = 8,
    parameter int unsigned        DATA_W     = 16,
    parameter int unsigned        MEM_WORDS  = 28,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0,
    parameter logic [DATA_W-1:0]  HALT_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [DATA_W-1:0] imem_instr,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              halted,
    output logic              fault
);

    localparam int unsigned LAST_ADDR = 2 * MEM_WORDS - 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]        state, state_d;
    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight_v;
    logic [ADDR_W-1:0] inflight_pc;
    logic              skid_v;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    logic              in_run;
    logic              target_ok;
    logic              do_redirect;
    logic              advance;
    logic              do_load;
    logic [DATA_W-1:0] load_instr;
    logic [ADDR_W-1:0] load_pc;
    logic              halt_hit;
    logic              do_start;

    // Address/enable are combinational off the PC register so the memory sees them this cycle.
    assign imem_addr  = in_run ? fetch_pc : '0;
    assign imem_rd_en = in_run && (32'(fetch_pc) <= LAST_ADDR);

    // Next-state and pipeline control decode.
    always_comb begin
        state_d     = state;
        in_run      = (state == S_RUN);
        target_ok   = !redirect_addr[0] && (32'(redirect_addr) <= LAST_ADDR);
        do_redirect = in_run && redirect;
        advance     = in_run && !redirect && !stall;
        do_load     = advance && (skid_v || inflight_v);
        load_instr  = skid_v ? skid_instr : imem_instr;
        load_pc     = skid_v ? skid_pc : inflight_pc;
        halt_hit    = do_load && (load_instr == HALT_INSTR);
        do_start    = ((state == S_IDLE) || (state == S_HALT)) && start;

        case (state)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (do_redirect) begin
                    if (!target_ok) state_d = S_FAULT;
                end else if (halt_hit) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= START_ADDR;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
            skid_v      <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state <= state_d;
            if (do_start) begin
                fetch_pc   <= START_ADDR;
                inflight_v <= 1'b0;
                skid_v     <= 1'b0;
                if_valid   <= 1'b0;
                halted     <= 1'b0;
            end else if ((state == S_HALT) && !stall) begin
                if_valid <= 1'b0;
                halted   <= 1'b1;
            end else if (do_redirect) begin
                if (target_ok) begin
                    fetch_pc <= redirect_addr;
                end else begin
                    fault <= 1'b1;
                end
                inflight_v <= 1'b0;
                skid_v     <= 1'b0;
                if_valid   <= 1'b0;
            end else if (in_run && stall) begin
                // The memory re-reads the held PC next cycle, so park the in-flight word now.
                if (inflight_v && !skid_v) begin
                    skid_instr <= imem_instr;
                    skid_pc    <= inflight_pc;
                    skid_v     <= 1'b1;
                    inflight_v <= 1'b0;
                end
            end else if (advance) begin
                if (imem_rd_en) begin
                    fetch_pc    <= fetch_pc + ADDR_W'(2);
                    inflight_pc <= fetch_pc;
                end
                inflight_v <= imem_rd_en && !halt_hit;
                skid_v     <= 1'b0;
                if (do_load) begin
                    if_instr <= load_instr;
                    if_pc    <= load_pc;
                    if_valid <= 1'b1;
                end else begin
                    if_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, hand sequences for fault/halt/
// end-of-memory/reset, and randomized traffic against a queue-based reference model.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stall, redirect;
    logic [7:0]  redirect_addr;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_instr;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid, halted, fault;

    logic [15:0] mem [128];

    int n_pass = 0;
    int n_total = 0;

    imem_fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_instr(imem_instr),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory, word index = byte address / 2.
    always @(posedge clk) imem_instr <= mem[imem_addr[7:1]];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic tick(input logic r, input logic st, input logic sl, input logic rd,
                        input logic [7:0] ra);
        rst = r; start = st; stall = sl; redirect = rd; redirect_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [7:0] pc,
                           input logic [15:0] ins, input logic rden, input logic [7:0] addr,
                           input logic h, input logic f, input logic cmpd);
        chk({tag, ".valid"}, 32'(if_valid), 32'(v));
        if (cmpd) begin
            chk({tag, ".pc"}, 32'(if_pc), 32'(pc));
            chk({tag, ".instr"}, 32'(if_instr), 32'(ins));
        end
        chk({tag, ".rd_en"}, 32'(imem_rd_en), 32'(rden));
        if (rden) chk({tag, ".addr"}, 32'(imem_addr), 32'(addr));
        chk({tag, ".halted"}, 32'(halted), 32'(h));
        chk({tag, ".fault"}, 32'(fault), 32'(f));
    endtask

    typedef struct {
        logic        r, st, sl, rd;
        logic [7:0]  ra;
        logic        v;
        logic [7:0]  pc;
        logic [15:0] ins;
        logic        rden;
        logic [7:0]  addr;
        logic        cmpd;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic st, input logic sl, input logic rd,
                                 input logic [7:0] ra, input logic v, input logic [7:0] pc,
                                 input logic [15:0] ins, input logic rden, input logic [7:0] addr,
                                 input logic cmpd);
        vec_t x;
        x.r = r; x.st = st; x.sl = sl; x.rd = rd; x.ra = ra;
        x.v = v; x.pc = pc; x.ins = ins; x.rden = rden; x.addr = addr; x.cmpd = cmpd;
        return x;
    endfunction

    // Reference model: issued-but-undelivered PCs wait in a queue; delivery reads mem directly.
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
    int          m_st;
    logic [7:0]  m_pc;
    logic [7:0]  m_q [$];
    logic        m_valid, m_halted, m_fault;
    logic [7:0]  m_ipc;
    logic [15:0] m_instr;

    task automatic model_edge(input logic r, input logic st, input logic sl, input logic rd,
                              input logic [7:0] ra);
        logic [7:0] p;
        if (r) begin
            m_st = M_IDLE; m_pc = 8'd0; m_q.delete();
            m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_ipc = 8'd0; m_instr = 16'd0;
        end else if ((m_st == M_IDLE || m_st == M_HALT) && st) begin
            m_st = M_RUN; m_pc = 8'd0; m_q.delete(); m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_st == M_HALT) begin
            if (!sl) begin m_valid = 1'b0; m_halted = 1'b1; end
        end else if (m_st == M_RUN) begin
            if (rd) begin
                m_q.delete(); m_valid = 1'b0;
                if (ra % 2 == 0 && ra <= 54) m_pc = ra;
                else begin m_st = M_FAULT; m_fault = 1'b1; end
            end else if (!sl) begin
                m_valid = 1'b0;
                if (m_q.size() > 0) begin
                    p = m_q.pop_front();
                    m_ipc = p; m_instr = mem[p / 2]; m_valid = 1'b1;
                end
                if (m_valid && m_instr == 16'h0000) m_st = M_HALT;
                else if (m_pc <= 54) begin m_q.push_back(m_pc); m_pc = m_pc + 8'd2; end
            end
        end
    endtask

    vec_t vt [16];

    initial begin
        logic r, st, sl, rd;
        logic [7:0] ra;
        logic m_rd;

        for (int n = 0; n < 128; n++) mem[n] = 16'h1000 + 16'(n);

        // Start latency, in-order delivery, 3-cycle stall with skid, redirect under stall.
        vt[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 8'd0,  16'h0000, 1'b0, 8'd0,  1'b1);
        vt[1]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 8'd0,  16'h0000, 1'b1, 8'd0,  1'b0);
        vt[2]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 8'd0,  16'h0000, 1'b1, 8'd2,  1'b0);
        vt[3]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd0,  16'h1000, 1'b1, 8'd4,  1'b1);
        vt[4]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd2,  16'h1001, 1'b1, 8'd6,  1'b1);
        vt[5]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd4,  16'h1002, 1'b1, 8'd8,  1'b1);
        vt[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd4,  16'h1002, 1'b1, 8'd8,  1'b1);
        vt[7]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd4,  16'h1002, 1'b1, 8'd8,  1'b1);
        vt[8]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd4,  16'h1002, 1'b1, 8'd8,  1'b1);
        vt[9]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd6,  16'h1003, 1'b1, 8'd10, 1'b1);
        vt[10] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd8,  16'h1004, 1'b1, 8'd12, 1'b1);
        vt[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd10, 16'h1005, 1'b1, 8'd14, 1'b1);
        vt[12] = mkv(1'b0, 1'b0, 1'b1, 1'b1, 8'd20, 1'b0, 8'd0,  16'h0000, 1'b1, 8'd20, 1'b0);
        vt[13] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 8'd0,  16'h0000, 1'b1, 8'd22, 1'b0);
        vt[14] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd20, 16'h100A, 1'b1, 8'd24, 1'b1);
        vt[15] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd22, 16'h100B, 1'b1, 8'd26, 1'b1);

        for (int i = 0; i < 16; i++) begin
            tick(vt[i].r, vt[i].st, vt[i].sl, vt[i].rd, vt[i].ra);
            chk_all($sformatf("vec%0d", i), vt[i].v, vt[i].pc, vt[i].ins, vt[i].rden,
                    vt[i].addr, 1'b0, 1'b0, vt[i].cmpd);
        end

        // Odd target faults; start is ignored until reset; word-28 target also faults.
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd7);
        chk_all("fault_odd", 1'b0, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        chk_all("fault_start", 1'b0, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("fault_rst", 1'b0, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("refetch0", 1'b1, 8'd0, 16'h1000, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd56);
        chk_all("fault_56", 1'b0, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Halt word at byte 10: delivered once, then halted; start refetches from 0.
        mem[5] = 16'h0000;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int j = 1; j <= 7; j++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            if (j >= 2) chk($sformatf("halt_seq%0d.pc", j), 32'(if_pc), 32'(2 * (j - 2)));
        end
        chk_all("halt_deliver", 1'b1, 8'd10, 16'h0000, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("halted", 1'b0, 8'd10, 16'h0000, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd20);
        chk_all("halt_ign_redir", 1'b0, 8'd10, 16'h0000, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        chk_all("halt_restart", 1'b0, 8'd0, 16'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        mem[5] = 16'h1005;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("halt_refetch", 1'b1, 8'd0, 16'h1000, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1);

        // Sequential run off the end of memory, then redirect resumes, then mid-run reset.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int j = 1; j <= 28; j++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("end_52", 1'b1, 8'd52, 16'h101A, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("end_54", 1'b1, 8'd54, 16'h101B, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("end_drain", 1'b0, 8'd54, 16'h101B, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("end_idle", 1'b0, 8'd54, 16'h101B, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk_all("end_redir", 1'b0, 8'd0, 16'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("end_resume", 1'b1, 8'd0, 16'h1000, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_all("midrun_rst", 1'b0, 8'd0, 16'h0000, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("midrun_rst.addr", 32'(imem_addr), 32'd0);

        // Randomized traffic with sprinkled halt words against the reference model.
        for (int n = 0; n < 128; n++)
            mem[n] = ($urandom_range(0, 11) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
        model_edge(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 99) < 1);
            st = ($urandom_range(0, 99) < 8);
            sl = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 6);
            ra = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'(2 * $urandom_range(0, 27));
            model_edge(r, st, sl, rd, ra);
            tick(r, st, sl, rd, ra);
            m_rd = (m_st == M_RUN) && (m_pc <= 54);
            chk_all($sformatf("rand%0d", c), m_valid, m_ipc, m_instr, m_rd, m_pc,
                    m_halted, m_fault, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
